flash_pixel_fetch: RTL
======================

// Module: flash_pixel_fetch
// PURPOSE
//  Downstream of the flash address sequencer. Watches the 32-bit pixel address it publishes
//  (0..31249, new value every 2048 clk, wraps to 0). Each new address -> one Avalon-MM read
//  to parallel flash. Returned pixel byte is buffered in a small FIFO with a valid/ready
//  output for the display/pixel pipeline. Sticky timeout flag reports a flash that never answers.
// PARAMETERS
//  FLASH_AW    23          flash byte-address width
//  DATA_W      8           flash read data / pixel width
//  BASE_ADDR   23'h000000  flash offset of pixel 0 in the image
//  FIFO_DEPTH  4           output FIFO entries (power of 2, >=2)
//  TIMEOUT     255         max cycles in WAIT_DATA before abort (8-bit counter)
// PORTS
//  clk              in   1                system clock
//  rst_n            in   1                synchronous active-low reset
//  pixel_addr       in   32               pixel index from address sequencer
//  fl_address       out  FLASH_AW         flash read address
//  fl_read          out  1                read request
//  fl_waitrequest   in   1                flash stalls request while high
//  fl_readdata      in   DATA_W           flash read data
//  fl_readdatavalid in   1                fl_readdata valid this cycle
//  pix_data         out  DATA_W           FIFO head pixel
//  pix_index        out  16               pixel_addr[15:0] belonging to pix_data
//  pix_valid        out  1                FIFO not empty
//  pix_ready        in   1                consumer accepts head when pix_valid&pix_ready
//  fifo_level       out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  err_timeout      out  1                sticky: a read was aborted on timeout
// BEHAVIOUR
//  Reset (rst_n low at posedge, synchronous): state=IDLE, fl_read=0, fl_address=0, FIFO empty,
//   pix_valid=0, pix_data=0, pix_index=0, fifo_level=0, err_timeout=0, pending=0,
//   last_addr=32'hFFFF_FFFF (so the first address after reset always triggers a fetch).
//   Reset mid-transaction aborts it; late fl_readdatavalid after reset is ignored (state=IDLE).
//  Change detect: every cycle, if pixel_addr != last_addr: last_addr<=pixel_addr, req_addr<=
//   pixel_addr, pending<=1. Only the newest address is kept; an address superseded before
//   its fetch starts is dropped (wrap 31249->0 is an ordinary change).
//  fl_address = BASE_ADDR + req_addr[FLASH_AW-1:0], modulo 2^FLASH_AW; latched on REQ entry.
//  FSM:
//   IDLE      : pending -> REQ (fl_read=1 next cycle, pending<=0).
//   REQ       : fl_read=1, fl_address stable; fl_waitrequest=0 -> WAIT_DATA, fl_read<=0.
//   WAIT_DATA : fl_readdatavalid -> capture {index,data}; push if FIFO has room (not full, or
//               full with pop this cycle) -> IDLE, else -> PUSH. Timer counts cycles here;
//               timer==TIMEOUT with no valid -> IDLE, err_timeout<=1, no push.
//   PUSH      : hold captured entry; push when room -> IDLE.
//  fl_readdatavalid outside WAIT_DATA is ignored. Change detect runs in all states.
//  FIFO: push/pop same cycle allowed at any level (level unchanged); pop only if pix_valid;
//   pix_data/pix_index show head combinationally from storage; order preserved.
//  Latency: address change sampled at edge E; fl_read high from E+1; with waitrequest=0 and
//   read latency 1, entry pushed at E+3, pix_valid high after E+3.
//  err_timeout clears only on reset.
// TESTING
//  1 Reset, pixel_addr=0, waitrequest=0, latency 1 -> fl_read 1 cycle, fl_address=BASE_ADDR,
//    pix_valid after 3 edges, pix_index=0, pix_data=flash byte.
//  2 waitrequest held high 5 cycles -> fl_read and fl_address held constant 6 cycles, one read.
//  3 pixel_addr steps 31248,31249,0 at 2048-cycle spacing, pix_ready=1 -> three pixels, indices
//    31248,31249,0, fl_address wraps to BASE_ADDR.
//  4 pix_ready=0, 6 address changes -> fifo_level saturates at 4, FSM holds in PUSH, no loss
//    of the 5th entry; pix_ready=1 -> in-order drain, 6th fetched after 5th pushed.
//  5 Never assert readdatavalid -> abort after 255 cycles in WAIT_DATA, err_timeout=1 sticky,
//    next address change fetches normally.
//  6 Assert rst_n=0 during WAIT_DATA, then readdatavalid -> no push, all outputs at reset values.

Source files
------------

// File: rtl/flash_pixel_fetch.sv
// Fetches one flash byte per pixel-address change and queues {index, data} in a small FIFO.
// A sticky flag records any read that was abandoned because the flash never answered.
module flash_pixel_fetch #(
  parameter int unsigned           FLASH_AW   = 23,
  parameter int unsigned           DATA_W     = 8,
  parameter logic [FLASH_AW-1:0]   BASE_ADDR  = '0,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   pixel_addr,
  output logic [FLASH_AW-1:0]           fl_address,
  output logic                          fl_read,
  input  logic                          fl_waitrequest,
  input  logic [DATA_W-1:0]             fl_readdata,
  input  logic                          fl_readdatavalid,
  output logic [DATA_W-1:0]             pix_data,
  output logic [15:0]                   pix_index,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_timeout
);

  localparam int unsigned      PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned      LvlW       = PtrW + 1;
  localparam logic [LvlW-1:0]  LevelFull  = LvlW'(FIFO_DEPTH);
  localparam logic [7:0]       TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StPush} state_e;

  state_e                state_q, state_d;
  logic [31:0]           last_addr_q, last_addr_d;
  logic [31:0]           req_addr_q, req_addr_d;
  logic                  pending_q, pending_d;
  logic [FLASH_AW-1:0]   fl_address_q, fl_address_d;
  logic [15:0]           cur_index_q, cur_index_d;
  logic [7:0]            timer_q, timer_d;
  logic [DATA_W-1:0]     cap_data_q, cap_data_d;
  logic [15:0]           cap_index_q, cap_index_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     mem_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_data_d [FIFO_DEPTH];
  logic [15:0]           mem_index_q [FIFO_DEPTH];
  logic [15:0]           mem_index_d [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;

  logic                  push, pop, room;
  logic [DATA_W-1:0]     push_data;
  logic [15:0]           push_index;

  // A full FIFO still has room when its head leaves in the same cycle.
  assign pop  = (level_q != '0) && pix_ready;
  assign room = (level_q != LevelFull) || pop;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    last_addr_d  = last_addr_q;
    req_addr_d   = req_addr_q;
    fl_address_d = fl_address_q;
    cur_index_d  = cur_index_q;
    timer_d      = timer_q;
    cap_data_d   = cap_data_q;
    cap_index_d  = cap_index_q;
    err_d        = err_q;
    push         = 1'b0;
    push_data    = fl_readdata;
    push_index   = cur_index_q;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d      = StReq;
          pending_d    = 1'b0;
          fl_address_d = BASE_ADDR + req_addr_q[FLASH_AW-1:0];
          cur_index_d  = req_addr_q[15:0];
        end
      end
      StReq: begin
        if (!fl_waitrequest) begin
          state_d = StWaitData;
          timer_d = 8'd1;
        end
      end
      StWaitData: begin
        if (fl_readdatavalid) begin
          cap_data_d  = fl_readdata;
          cap_index_d = cur_index_q;
          if (room) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StPush;
          end
        end else if (timer_q == TimeoutCnt) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StPush: begin
        push_data  = cap_data_q;
        push_index = cap_index_q;
        if (room) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Newest address wins; it overrides a pending clear taken in the same cycle.
    if (pixel_addr != last_addr_q) begin
      last_addr_d = pixel_addr;
      req_addr_d  = pixel_addr;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    mem_data_d  = mem_data_q;
    mem_index_d = mem_index_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (push) begin
      mem_data_d[wr_ptr_q]  = push_data;
      mem_index_d[wr_ptr_q] = push_index;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_addr_q  <= 32'hFFFF_FFFF;
      req_addr_q   <= '0;
      pending_q    <= 1'b0;
      fl_address_q <= '0;
      cur_index_q  <= '0;
      timer_q      <= '0;
      cap_data_q   <= '0;
      cap_index_q  <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i]  <= '0;
        mem_index_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      last_addr_q  <= last_addr_d;
      req_addr_q   <= req_addr_d;
      pending_q    <= pending_d;
      fl_address_q <= fl_address_d;
      cur_index_q  <= cur_index_d;
      timer_q      <= timer_d;
      cap_data_q   <= cap_data_d;
      cap_index_q  <= cap_index_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      mem_data_q   <= mem_data_d;
      mem_index_q  <= mem_index_d;
    end
  end

  assign fl_read     = (state_q == StReq);
  assign fl_address  = fl_address_q;
  assign pix_valid   = (level_q != '0);
  assign pix_data    = mem_data_q[rd_ptr_q];
  assign pix_index   = mem_index_q[rd_ptr_q];
  assign fifo_level  = level_q;
  assign err_timeout = err_q;

endmodule
